// File: rtl/board_io_pkg.sv
// Shared defaults for the board IO front end: parameter defaults and the
// PWM duty word type for the default resolution.
package board_io_pkg;

   localparam int DefNumIn          = 8;
   localparam int DefDebounceCycles = 500000;
   localparam int DefNumPwm         = 12;
   localparam int DefPwmRes         = 8;

   // Duty word at the default PWM resolution.
   typedef logic [DefPwmRes-1:0] pwm_duty_t;

endpackage

// File: rtl/board_io_frontend_if.sv
// Board-side IO bundle: raw inputs, conditioned levels/edges, interrupt
// control/status and PWM duty/outputs. The slave modport is the front end.
interface board_io_frontend_if
   import board_io_pkg::*;
#(
   parameter int NumIn  = DefNumIn,
   parameter int NumPwm = DefNumPwm,
   parameter int PwmRes = DefPwmRes
);

   logic [NumIn-1:0]         gp_raw_i;
   logic [NumIn-1:0]         gp_o;
   logic [NumIn-1:0]         gp_rise_o;
   logic [NumIn-1:0]         gp_fall_o;
   logic [NumIn-1:0]         irq_en_i;
   logic [NumIn-1:0]         irq_clear_i;
   logic [NumIn-1:0]         irq_pend_o;
   logic                     irq_o;
   logic [NumPwm*PwmRes-1:0] pwm_duty_i;
   logic [NumPwm-1:0]        pwm_o;

   modport slave (
      input  gp_raw_i, irq_en_i, irq_clear_i, pwm_duty_i,
      output gp_o, gp_rise_o, gp_fall_o, irq_pend_o, irq_o, pwm_o
   );

   modport master (
      output gp_raw_i, irq_en_i, irq_clear_i, pwm_duty_i,
      input  gp_o, gp_rise_o, gp_fall_o, irq_pend_o, irq_o, pwm_o
   );

endinterface

// File: rtl/board_io_debounce.sv
// One input bit: two-flop synchroniser, hold-time debounce counter and
// registered rise/fall pulses aligned with the first cycle of the new level.
module board_io_debounce
   import board_io_pkg::*;
#(
   parameter int DebounceCycles = DefDebounceCycles
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int              CntW   = $clog2(DebounceCycles + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

   logic            s1_q, s2_q;
   logic            stable_q, stable_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            rise_q, rise_d;
   logic            fall_q, fall_d;

   // Synchroniser chain for the asynchronous pin.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= raw_i;
         s2_q <= s1_q;
      end
   end

   // Count consecutive cycles the synced level differs from the accepted one;
   // any return to the accepted level restarts the count.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      if (s2_q != stable_q) begin
         if (cnt_q == CntMax) begin
            stable_d = s2_q;
            rise_d   = s2_q;
            fall_d   = ~s2_q;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   // Debounce state and edge pulse registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stable_q <= 1'b0;
         cnt_q    <= '0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
      end
   end

   assign level_o = stable_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/board_io_frontend.sv
// Board IO front end: per-bit debounced inputs with edge interrupts and
// sticky pending, plus phase-aligned multi-channel PWM with duty shadowing.
module board_io_frontend
   import board_io_pkg::*;
#(
   parameter int NumIn          = DefNumIn,
   parameter int DebounceCycles = DefDebounceCycles,
   parameter int NumPwm         = DefNumPwm,
   parameter int PwmRes         = DefPwmRes
) (
   input  logic                clk_sys_i,
   input  logic                rst_sys_ni,
   board_io_frontend_if.slave  io
);

   logic [NumIn-1:0]  level;
   logic [NumIn-1:0]  rise;
   logic [NumIn-1:0]  fall;
   logic [NumIn-1:0]  pend_q, pend_d;
   logic [PwmRes-1:0] cnt_q, cnt_d;
   logic              cnt_wrap;

   genvar gi;

   generate
      for (gi = 0; gi < NumIn; gi++) begin : g_in
         board_io_debounce #(
            .DebounceCycles(DebounceCycles)
         ) u_debounce (
            .clk_i   (clk_sys_i),
            .rst_ni  (rst_sys_ni),
            .raw_i   (io.gp_raw_i[gi]),
            .level_o (level[gi]),
            .rise_o  (rise[gi]),
            .fall_o  (fall[gi])
         );
      end
   endgenerate

   // Pending bits: an enabled edge sets, write-1 clears, set wins on a tie.
   always_comb begin
      pend_d = (pend_q & ~io.irq_clear_i) | ((rise | fall) & io.irq_en_i);
   end

   // Sticky pending register.
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign io.gp_o       = level;
   assign io.gp_rise_o  = rise;
   assign io.gp_fall_o  = fall;
   assign io.irq_pend_o = pend_q;
   assign io.irq_o      = |pend_q;

   // Shared free-running PWM counter; the last count is the duty reload point.
   always_comb begin
      cnt_d    = cnt_q + PwmRes'(1);
      cnt_wrap = (cnt_q == {PwmRes{1'b1}});
   end

   // PWM counter register.
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   generate
      for (gi = 0; gi < NumPwm; gi++) begin : g_pwm
         logic [PwmRes-1:0] duty_q, duty_d;
         logic              pwm_q;

         // Shadow the duty input only at the wrap so a period is never cut short.
         always_comb begin
            duty_d = cnt_wrap ? io.pwm_duty_i[gi*PwmRes +: PwmRes] : duty_q;
         end

         // Duty shadow and registered compare output.
         always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
            if (!rst_sys_ni) begin
               duty_q <= '0;
               pwm_q  <= 1'b0;
            end else begin
               duty_q <= duty_d;
               pwm_q  <= (cnt_q < duty_q);
            end
         end

         assign io.pwm_o[gi] = pwm_q;
      end
   endgenerate

endmodule
